// File: rtl/tohost_monitor_if.sv
// Store-port snoop bundle between the core's data-memory store port and the tohost monitor.
// The core (or harness) drives the master side; the monitor only listens.
interface tohost_monitor_if;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        retire;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output retire
   );

   modport slave (
      input mem_we,
      input mem_addr,
      input mem_wdata,
      input retire
   );
endinterface

// File: rtl/tohost_monitor.sv
// Decodes riscv-tests tohost stores into sticky pass/fail/timeout status.
// Also counts cycles and retired instructions while the test is running.
module tohost_monitor #(
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
   parameter int unsigned TIMEOUT     = 5000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   tohost_monitor_if.slave  bus,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [30:0]      fail_id,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt,
   output logic             halt_req
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StPass    = 2'd1,
      StFail    = 2'd2,
      StTimeout = 2'd3
   } state_e;

   localparam bit               TimeoutEn   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax      = '1;

   state_e           state_q, state_d;
   logic [30:0]      fail_id_q, fail_id_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         fail_id_q <= '0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         fail_id_q <= fail_id_d;
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   // An even tohost word (console/syscall traffic) still takes priority over the
   // timeout check in that cycle, so it suppresses a timeout landing on the same edge.
   always_comb begin
      state_d   = state_q;
      fail_id_d = fail_id_q;
      cycle_d   = cycle_q;
      instret_d = instret_q;
      hit       = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);

      if (state_q == StRun) begin
         if (cycle_q != CntMax) begin
            cycle_d = cycle_q + 1'b1;
         end
         if (bus.retire && (instret_q != CntMax)) begin
            instret_d = instret_q + 1'b1;
         end

         if (hit && (bus.mem_wdata == 32'h1)) begin
            state_d = StPass;
         end else if (hit && bus.mem_wdata[0]) begin
            state_d   = StFail;
            fail_id_d = bus.mem_wdata[31:1];
         end else if (hit) begin
            state_d = StRun;
         end else if (TimeoutEn && (cycle_q == TimeoutLast)) begin
            state_d = StTimeout;
         end
      end
   end

   assign done        = (state_q != StRun);
   assign pass        = (state_q == StPass);
   assign fail        = (state_q == StFail);
   assign timeout     = (state_q == StTimeout);
   assign fail_id     = fail_id_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
   assign halt_req    = done;

endmodule

// File: tb/tb_tohost_monitor.sv
// Self-checking bench: three monitor instances with different TIMEOUT/CNT_W share one
// store bus and are compared against a behavioural model, a vector table and hand sequences.
module tb_tohost_monitor;

   localparam logic [31:0] TH = 32'h0000_1000;

   logic clk;
   logic rst;
   tohost_monitor_if bus ();

   logic        doneW[3], passW[3], failW[3], tmoW[3], haltW[3];
   logic [30:0] fidW[3];
   logic [31:0] cycW[2], instW[2];
   logic [3:0]  cycC, instC;

   tohost_monitor #(.TOHOST_ADDR(TH), .TIMEOUT(20), .CNT_W(32)) dutA (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .done(doneW[0]), .pass(passW[0]), .fail(failW[0]), .fail_id(fidW[0]),
      .timeout(tmoW[0]), .cycle_cnt(cycW[0]), .instret_cnt(instW[0]), .halt_req(haltW[0]));

   tohost_monitor #(.TOHOST_ADDR(TH), .TIMEOUT(10), .CNT_W(32)) dutB (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .done(doneW[1]), .pass(passW[1]), .fail(failW[1]), .fail_id(fidW[1]),
      .timeout(tmoW[1]), .cycle_cnt(cycW[1]), .instret_cnt(instW[1]), .halt_req(haltW[1]));

   tohost_monitor #(.TOHOST_ADDR(TH), .TIMEOUT(0), .CNT_W(4)) dutC (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .done(doneW[2]), .pass(passW[2]), .fail(failW[2]), .fail_id(fidW[2]),
      .timeout(tmoW[2]), .cycle_cnt(cycC), .instret_cnt(instC), .halt_req(haltW[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   // Reference model: outcome kind (0 running, 1 pass, 2 fail, 3 timeout) plus counters.
   typedef struct {
      int     kind;
      longint cyc;
      longint inst;
      longint fid;
   } model_t;

   model_t      mdl[3];
   int          tmoP[3]  = '{20, 10, 0};
   longint      maxP[3]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

   typedef struct {
      logic        r, we;
      logic [31:0] addr, wdata;
      logic        ret;
      logic        done, pass, fail;
      logic [30:0] fid;
      logic        tmo;
      logic [31:0] cyc, inst;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic model_t modelStep(model_t s, int tmo, longint maxc, logic r, logic we,
                                        logic [31:0] addr, logic [31:0] wdata, logic ret);
      model_t n;
      logic   isTohost;
      n = s;
      if (r) begin
         n.kind = 0; n.cyc = 0; n.inst = 0; n.fid = 0;
         return n;
      end
      if (s.kind != 0) return n;
      isTohost = we && (addr == TH);
      n.cyc  = (s.cyc >= maxc) ? maxc : s.cyc + 1;
      n.inst = (ret && s.inst < maxc) ? s.inst + 1 : s.inst;
      if (isTohost) begin
         if (wdata == 32'h1) n.kind = 1;
         else if (wdata % 2 == 1) begin
            n.kind = 2;
            n.fid  = wdata / 2;
         end
      end else if (tmo != 0 && s.cyc == tmo - 1) begin
         n.kind = 3;
      end
      return n;
   endfunction

   task automatic checkModels();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] ac, ai;
         ac = (i == 2) ? {28'd0, cycC}  : cycW[i];
         ai = (i == 2) ? {28'd0, instC} : instW[i];
         check($sformatf("dut%0d.done", i),    doneW[i], mdl[i].kind != 0);
         check($sformatf("dut%0d.pass", i),    passW[i], mdl[i].kind == 1);
         check($sformatf("dut%0d.fail", i),    failW[i], mdl[i].kind == 2);
         check($sformatf("dut%0d.timeout", i), tmoW[i],  mdl[i].kind == 3);
         check($sformatf("dut%0d.halt", i),    haltW[i], mdl[i].kind != 0);
         check($sformatf("dut%0d.fail_id", i), fidW[i],  mdl[i].fid);
         check($sformatf("dut%0d.cycle", i),   ac,       mdl[i].cyc);
         check($sformatf("dut%0d.instret", i), ai,       mdl[i].inst);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ret);
      rst           = r;
      bus.mem_we    = we;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.retire    = ret;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         mdl[i] = modelStep(mdl[i], tmoP[i], maxP[i], r, we, addr, wdata, ret);
      end
      checkModels();
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      check($sformatf("vec%0d.done", idx),    doneW[0], v.done);
      check($sformatf("vec%0d.halt", idx),    haltW[0], v.done);
      check($sformatf("vec%0d.pass", idx),    passW[0], v.pass);
      check($sformatf("vec%0d.fail", idx),    failW[0], v.fail);
      check($sformatf("vec%0d.fail_id", idx), fidW[0],  v.fid);
      check($sformatf("vec%0d.timeout", idx), tmoW[0],  v.tmo);
      check($sformatf("vec%0d.cycle", idx),   cycW[0],  v.cyc);
      check($sformatf("vec%0d.instret", idx), instW[0], v.inst);
   endtask

   task automatic addVec(input logic r, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ret,
                         input logic d, input logic p, input logic f, input logic [30:0] fid,
                         input logic t, input logic [31:0] cyc, input logic [31:0] inst);
      vec_t v;
      v.r = r; v.we = we; v.addr = addr; v.wdata = wdata; v.ret = ret;
      v.done = d; v.pass = p; v.fail = f; v.fid = fid; v.tmo = t; v.cyc = cyc; v.inst = inst;
      vecs.push_back(v);
   endtask

   task automatic idle(input int n, input logic ret);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, ret);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 0, 0};
      rst = 1'b1;
      bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.retire = 1'b0;

      // Vectors against the TIMEOUT=20 instance; expected values worked out by hand.
      addVec(1, 0, 0,      0,          0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 7; k++)
         addVec(0, 0, 0,   0,          1, 0, 0, 0, 0, 0, k, k);
      addVec(0, 1, TH,     32'h1,      1, 1, 1, 0, 0, 0, 8, 8);
      addVec(0, 1, TH,     32'h5,      1, 1, 1, 0, 0, 0, 8, 8);
      addVec(0, 1, 32'h20, 32'h7,      1, 1, 1, 0, 0, 0, 8, 8);
      addVec(1, 0, 0,      0,          0, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, TH,     32'h7,      0, 1, 0, 1, 3, 0, 1, 0);
      addVec(0, 1, TH,     32'h1,      1, 1, 0, 1, 3, 0, 1, 0);
      addVec(1, 0, 0,      0,          0, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, TH,     32'h2,      1, 0, 0, 0, 0, 0, 1, 1);
      addVec(0, 1, TH,     32'h0,      0, 0, 0, 0, 0, 0, 2, 1);
      addVec(0, 1, TH + 4, 32'h1,      1, 0, 0, 0, 0, 0, 3, 2);
      addVec(0, 1, 32'hDEAD_0000, 32'h1, 1, 0, 0, 0, 0, 0, 4, 3);
      addVec(0, 1, TH,     32'h1,      0, 1, 1, 0, 0, 0, 5, 3);
      addVec(1, 0, 0,      0,          0, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, TH,     32'hFFFF_FFFF, 1, 1, 0, 1, 31'h7FFF_FFFF, 0, 1, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].r, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ret);
         checkOutput(vecs[i], i);
      end

      // Timeout at 20 on dutA, holding afterwards; dutC saturates its 4-bit counters.
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      idle(19, 1'b1);
      check("tmo.pre.done",  doneW[0], 1'b0);
      check("tmo.pre.cycle", cycW[0],  32'd19);
      idle(1, 1'b1);
      check("tmo.timeout", tmoW[0],  1'b1);
      check("tmo.done",    doneW[0], 1'b1);
      check("tmo.halt",    haltW[0], 1'b1);
      check("tmo.pass",    passW[0], 1'b0);
      check("tmo.fail",    failW[0], 1'b0);
      check("tmo.cycle",   cycW[0],  32'd20);
      idle(10, 1'b1);
      check("tmo.hold.cycle", cycW[0], 32'd20);
      check("tmoB.cycle",     cycW[1], 32'd10);
      check("sat.cycle",      cycC,    4'd15);
      check("sat.instret",    instC,   4'd15);
      check("sat.done",       doneW[2], 1'b0);

      // Pass store landing exactly on dutB's timeout cycle: the store wins.
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      idle(9, 1'b0);
      applyStimulus(1'b0, 1'b1, TH, 32'h1, 1'b0);
      check("race.pass",    passW[1], 1'b1);
      check("race.timeout", tmoW[1],  1'b0);
      check("race.cycle",   cycW[1],  32'd10);

      // Randomized traffic with occasional resets, checked every cycle by the model.
      for (int n = 0; n < 1500; n++) begin
         logic        r, we, ret;
         logic [31:0] addr, wdata;
         int          sel;
         r   = ($urandom_range(0, 59) == 0);
         we  = ($urandom_range(0, 3) == 0);
         ret = $urandom_range(0, 1);
         sel = $urandom_range(0, 3);
         addr = (sel < 2) ? TH : (sel == 2) ? TH + 4 : $urandom;
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1:    wdata = 32'h1;
            2:       wdata = 32'h0;
            3:       wdata = {$urandom_range(0, 255), 1'b0};
            4:       wdata = {$urandom_range(0, 255), 1'b1};
            default: wdata = $urandom;
         endcase
         applyStimulus(r, we, addr, wdata, ret);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
- Sits directly downstream of the core's data-memory store port in the riscv-tests simulation harness.
- Snoops stores to the tohost word and decodes the riscv-tests completion protocol into sticky pass, fail and timeout status.
- Counts cycles and retired instructions.
- Asserts halt_req so the harness can stop the run deterministically instead of running a fixed tick count.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; compared on the full 32 bits.
- TIMEOUT, 5000, cycles after reset release before timeout is declared; 0 disables timeout.
- CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_we  in  1  store strobe from core data port, one store per cycle when high
- mem_addr  in  32  store byte address
- mem_wdata  in  32  store data
- retire  in  1  one instruction retired this cycle
- done  out  1  sticky; any terminal state reached
- pass  out  1  sticky; tohost written with 1
- fail  out  1  sticky; tohost written with odd value other than 1
- fail_id  out  31  mem_wdata[31:1] of the failing store (riscv-tests TESTNUM)
- timeout  out  1  sticky; TIMEOUT cycles elapsed without terminal store
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instret_cnt  out  CNT_W  retire pulses counted in RUN
- halt_req  out  1  equals done; harness stops on it

Behaviour:
- Reset (rst high at a rising edge):
  - state=RUN.
  - All outputs 0: done, pass, fail, fail_id, timeout, cycle_cnt, instret_cnt, halt_req.
  - rst asserted mid-run or after a terminal state returns to RUN with everything cleared. No state survives reset.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal; only rst leaves them.
- Tohost hit: mem_we=1 and mem_addr==TOHOST_ADDR.
- RUN, one registered update per cycle, priority order:
  - Hit with mem_wdata==32'h1 -> PASS.
  - Else hit with mem_wdata[0]==1 -> FAIL; fail_id <= mem_wdata[31:1].
  - Else hit with mem_wdata[0]==0 (syscall/console word, including 0) -> ignored; stay in RUN.
  - Else TIMEOUT!=0 and cycle_cnt==TIMEOUT-1 -> TIMEOUT.
  - Else stay in RUN.
- Simultaneous terminal tohost store and timeout condition in the same cycle: the store wins; timeout stays 0.
- Latency: status outputs are registered and assert on the rising edge that samples the store, visible the following cycle. halt_req=done, same cycle.
- cycle_cnt:
  - Increments by 1 on every edge while state==RUN, including the edge that leaves RUN.
  - Frozen once terminal.
  - Saturates at all-ones; never wraps.
- instret_cnt:
  - Increments on each edge with retire=1 while state==RUN, including the exiting edge.
  - Frozen once terminal; saturates at all-ones.
- Stores in terminal states, to any address, are ignored; status and fail_id do not change.
- Stores to TOHOST_ADDR+4 (fromhost) or other addresses have no effect.
- Exactly one of pass/fail/timeout is set when done=1. All three are 0 while done=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle; TIMEOUT=20: after cycle_cnt reaches 19, state TIMEOUT. Next cycle timeout=1, done=halt_req=1, cycle_cnt=20, pass=fail=0. cycle_cnt holds at 20 for 10 more cycles.
- Store 32'h1 to 32'h1000 at cycle 7, with retire=1 every cycle: next cycle pass=1, done=1, fail_id=0, cycle_cnt=8, instret_cnt=8. A later store of 32'h5 to 32'h1000 changes nothing.
- Store 32'h0000_0007 to 32'h1000: fail=1, fail_id=3, pass=0, timeout=0.
- Store 32'h0000_0002 then 32'h0 to 32'h1000, and 32'h1 to 32'h1004: no status change, done=0. A later store of 32'h1 to 32'h1000 yields pass=1.
- TIMEOUT=10; store 32'h1 to 32'h1000 on the cycle cycle_cnt==9: pass=1, timeout=0, cycle_cnt=10.
- Reach FAIL (fail_id=3), assert rst one cycle: all outputs 0, state RUN. A subsequent store of 32'h1 gives pass=1 with fail_id=0. Saturation check with CNT_W=4, TIMEOUT=0: cycle_cnt sticks at 15.
